// File: rtl/pipe_pkg.sv
// pipe_pkg: shared EX->MEM payload type and constants
package pipe_pkg;
   localparam int PIPE_DATA_W  = 32;
   localparam int PIPE_REG_AW  = 5;
   localparam int PIPE_MEMOP_W = 5;
   localparam logic [PIPE_MEMOP_W-1:0] MEMOP_NONE = '0;
   typedef struct packed {
      logic [PIPE_REG_AW-1:0]  wa;
      logic                    we;
      logic [PIPE_DATA_W-1:0]  wn;
      logic [PIPE_MEMOP_W-1:0] mem_e;
      logic [PIPE_DATA_W-1:0]  mem_n;
      logic [PIPE_DATA_W-1:0]  pc;
   } ex_mm_payload_t;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one payload register with its valid bit; load wins over clear
module pipe_slot #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic         valid,
   output logic [W-1:0] q
);
   // hold, load or drop the entry; active-low reset zeroes everything
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid <= 1'b0;
         q     <= '0;
      end else begin
         valid <= load | (valid & !clear);
         if (load) q <= d;
      end
   end
endmodule

// File: rtl/ex_mm_skid.sv
// ex_mm_skid: EX->MEM ready/valid stage with 2-entry skid; EX_MM_FWD_EN adds the bypass tap
module ex_mm_skid
   import pipe_pkg::*;
#(
   parameter int DATA_W  = PIPE_DATA_W,
   parameter int REG_AW  = PIPE_REG_AW,
   parameter int MEMOP_W = PIPE_MEMOP_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [REG_AW-1:0]  in_wa,
   input  logic               in_we,
   input  logic [DATA_W-1:0]  in_wn,
   input  logic [MEMOP_W-1:0] in_mem_e,
   input  logic [DATA_W-1:0]  in_mem_n,
   input  logic [DATA_W-1:0]  in_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [REG_AW-1:0]  out_wa,
   output logic               out_we,
   output logic [DATA_W-1:0]  out_wn,
   output logic [MEMOP_W-1:0] out_mem_e,
   output logic [DATA_W-1:0]  out_mem_n,
   output logic [DATA_W-1:0]  out_pc
`ifdef EX_MM_FWD_EN
   ,
   output logic               fwd_valid,
   output logic [REG_AW-1:0]  fwd_wa,
   output logic [DATA_W-1:0]  fwd_wn
`endif
);
   localparam int W = REG_AW + 1 + 3 * DATA_W + MEMOP_W;
   logic [W-1:0] in_p, head_d, head_q, skid_q;
   logic head_valid, skid_valid, acc, cons, head_load, skid_load, clr, head_we;
   assign in_p = {in_wa, in_we, in_wn, in_mem_e, in_mem_n, in_pc};
   // steering: in_ready comes only from the skid flop; flush overrides every load
   always_comb begin
      in_ready  = !skid_valid;
      acc       = in_valid & !skid_valid & !flush;
      cons      = head_valid & out_ready;
      head_load = !flush & (skid_valid ? cons : acc & (!head_valid | cons));
      head_d    = skid_valid ? skid_q : in_p;
      skid_load = acc & head_valid & !cons;
      clr       = flush | cons;
   end
   pipe_slot #(.W(W)) u_head (
      .clk(clk), .rst(rst), .load(head_load), .clear(clr),
      .d(head_d), .valid(head_valid), .q(head_q)
   );
   pipe_slot #(.W(W)) u_skid (
      .clk(clk), .rst(rst), .load(skid_load), .clear(clr),
      .d(in_p), .valid(skid_valid), .q(skid_q)
   );
   assign {out_wa, head_we, out_wn, out_mem_e, out_mem_n, out_pc} = head_q;
   assign out_valid = head_valid;
   assign out_we    = head_valid & head_we;
`ifdef EX_MM_FWD_EN
   logic [REG_AW-1:0] skid_wa;
   logic [DATA_W-1:0] skid_wn;
   logic skid_we, skid_hit;
   assign skid_wa = skid_q[W-1 -: REG_AW];
   assign skid_we = skid_q[W-1-REG_AW];
   assign skid_wn = skid_q[W-2-REG_AW -: DATA_W];
   // newer skid write shadows the head on the bypass tap
   always_comb begin
      skid_hit  = skid_valid & skid_we & (|skid_wa);
      fwd_valid = skid_hit | (head_valid & head_we & (|out_wa));
      fwd_wa    = skid_hit ? skid_wa : out_wa;
      fwd_wn    = skid_hit ? skid_wn : out_wn;
   end
`endif
endmodule

// File: tb/tb_ex_mm_skid.sv
// tb_ex_mm_skid: queue-model checker plus directed vectors for ex_mm_skid
module tb_ex_mm_skid;
   import pipe_pkg::*;
   logic clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0, in_we = 0;
   logic [4:0] in_wa = 0, in_mem_e = 0;
   logic [31:0] in_wn = 0, in_mem_n = 0, in_pc = 0;
   logic in_ready, out_valid, out_we;
   logic [4:0] out_wa, out_mem_e;
   logic [31:0] out_wn, out_mem_n, out_pc;
`ifdef EX_MM_FWD_EN
   logic fwd_valid;
   logic [4:0] fwd_wa;
   logic [31:0] fwd_wn;
`endif
   always #5 clk = ~clk;
   ex_mm_skid dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_wa(in_wa), .in_we(in_we), .in_wn(in_wn), .in_mem_e(in_mem_e),
      .in_mem_n(in_mem_n), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_wa(out_wa), .out_we(out_we), .out_wn(out_wn), .out_mem_e(out_mem_e),
      .out_mem_n(out_mem_n), .out_pc(out_pc)
`ifdef EX_MM_FWD_EN
      , .fwd_valid(fwd_valid), .fwd_wa(fwd_wa), .fwd_wn(fwd_wn)
`endif
   );
   ex_mm_payload_t mq[$];
   logic [31:0] got[$];
   bit chk = 0;
   int n_cmp = 0, n_bad = 0;
   task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask
   // model: the stage is a 2-deep FIFO; flush or reset empties it
   always @(posedge clk) begin
      bit a, c;
      ex_mm_payload_t b;
      if (!rst || flush) mq.delete();
      else begin
         a = in_valid && mq.size() < 2;
         c = mq.size() > 0 && out_ready;
         b = '{wa: in_wa, we: in_we, wn: in_wn, mem_e: in_mem_e, mem_n: in_mem_n, pc: in_pc};
         if (c) void'(mq.pop_front());
         if (a) mq.push_back(b);
      end
   end
   // compare every cycle away from the active edge
   always @(negedge clk) begin
      if (chk) begin
         check("out_valid", out_valid, mq.size() > 0);
         check("in_ready", in_ready, mq.size() < 2);
         if (mq.size() > 0) begin
            check("out_we", out_we, mq[0].we);
            check("out_wa", out_wa, mq[0].wa);
            check("out_wn", out_wn, mq[0].wn);
            check("out_mem_e", out_mem_e, mq[0].mem_e);
            check("out_mem_n", out_mem_n, mq[0].mem_n);
            check("out_pc", out_pc, mq[0].pc);
         end else check("out_we_idle", out_we, 0);
      end
      if (out_valid === 1'b1 && out_ready) got.push_back(out_wn);
   end
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(bit v, bit we, logic [4:0] wa, logic [31:0] wn);
      in_valid = v;
      in_we    = we;
      in_wa    = wa;
      in_wn    = wn;
      in_mem_e = wn[4:0];
      in_mem_n = ~wn;
      in_pc    = wn << 2;
   endtask
   initial begin
      drive(1, 1, 5'd3, 32'h5);
      cyc();
      chk = 1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      cyc();
      cyc();
      @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_we", out_we, 0);
      check("rst_wn", out_wn, 0);
      rst = 1;
      drive(0, 0, 0, 0);
      cyc();
      out_ready = 1;
      got.delete();
      for (int i = 1; i <= 8; i++) begin
         drive(1, 1, i[4:0], i);
         cyc();
         @(negedge clk);
         check("stream_lat", out_wn, i);
         check("stream_rdy", in_ready, 1);
      end
      drive(0, 0, 0, 0);
      repeat (2) cyc();
      check("stream_cnt", got.size(), 8);
      for (int i = 0; i < 8 && i < got.size(); i++) check("stream_seq", got[i], i + 1);
      out_ready = 0;
      drive(1, 1, 5'd3, 32'h11);
      cyc();
      drive(1, 1, 5'd4, 32'h22);
      cyc();
      drive(1, 1, 5'd5, 32'h99);
      cyc();
      drive(0, 0, 0, 0);
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_head", out_wn, 32'h11);
      got.delete();
      cyc();
      out_ready = 1;
      repeat (4) cyc();
      check("bp_cnt", got.size(), 2);
      if (got.size() == 2) begin
         check("bp_a", got[0], 32'h11);
         check("bp_b", got[1], 32'h22);
      end
      out_ready = 0;
      drive(1, 1, 5'd6, 32'h44);
      cyc();
      drive(1, 1, 5'd7, 32'h55);
      cyc();
      drive(1, 1, 5'd8, 32'h33);
      flush = 1;
      cyc();
      flush = 0;
      drive(0, 0, 0, 0);
      @(negedge clk);
      check("fl_valid", out_valid, 0);
      check("fl_ready", in_ready, 1);
      got.delete();
      out_ready = 1;
      repeat (3) cyc();
      check("fl_none", got.size(), 0);
      out_ready = 0;
      drive(1, 1, 5'd2, 32'h66);
      cyc();
      drive(0, 0, 0, 0);
      flush = 1;
      out_ready = 1;
      cyc();
      flush = 0;
      @(negedge clk);
      check("flc_valid", out_valid, 0);
      drive(1, 1, 5'd9, 32'h77);
      cyc();
      drive(0, 0, 0, 0);
      @(negedge clk);
      check("we_on", out_we, 1);
      cyc();
      @(negedge clk);
      check("we_valid_off", out_valid, 0);
      check("we_off", out_we, 0);
`ifdef EX_MM_FWD_EN
      out_ready = 0;
      drive(1, 1, 5'd0, 32'h5);
      cyc();
      drive(0, 0, 0, 0);
      @(negedge clk);
      check("fwd_zero", fwd_valid, 0);
      flush = 1;
      cyc();
      flush = 0;
      drive(1, 1, 5'd7, 32'hDEAD);
      cyc();
      drive(0, 0, 0, 0);
      @(negedge clk);
      check("fwd_valid", fwd_valid, 1);
      check("fwd_wa", fwd_wa, 7);
      check("fwd_wn", fwd_wn, 32'hDEAD);
`endif
      cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
